// File: rtl/tub_pkg.sv
// Shared types and constants for the tub value encoder: FSM states, 7-segment codes,
// decimal display limits.
package tub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    ENC
  } state_t;

  // Segment order is bit7..bit1 = a..g, bit0 = dp, active-high.
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_A     = 8'hEE;
  localparam logic [7:0] SEG_B     = 8'h3E;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_D     = 8'h7A;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_MINUS = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [31:0] DEC_MAX     = 32'd99_999_999;
  localparam logic [31:0] DEC_MAX_NEG = 32'd9_999_999;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit to 7-segment lookup (hex digits 0..F).
module seg_hex_decode
  import tub_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    unique case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/tub_value_encoder.sv
// Converts a 32-bit value into eight 7-segment codes, hex one-shot or decimal via double-dabble.
// Optional macro TUB_SIGNED_EN: decimal mode treats value as two's complement with a minus sign.
module tub_value_encoder
  import tub_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter logic [7:0]  BLANK_CODE = 8'h00,
  parameter logic [7:0]  OVF_CODE   = 8'h9E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] value,
  input  logic              dec_mode,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [7:0]        tub_1,
  output logic [7:0]        tub_2,
  output logic [7:0]        tub_3,
  output logic [7:0]        tub_4,
  output logic [7:0]        tub_5,
  output logic [7:0]        tub_6,
  output logic [7:0]        tub_7,
  output logic [7:0]        tub_8
);

  localparam int unsigned CntW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [31:0]       bcd_q, bcd_d, bcd_adj;
  logic              dec_q, dec_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic              load_q, load_d;
  logic              done_q, ovf_q;
  logic [7:0][7:0]   tub_q;

  logic [DATA_W-1:0] mag;
  logic              start_ovf;
  logic [7:0][3:0]   dig;
  logic [7:0][7:0]   seg;
  logic [7:0][7:0]   frame;
  logic [7:0]        blank;
  logic              lead;

`ifdef TUB_SIGNED_EN
  logic val_neg;
  logic neg_q, neg_d;

  always_comb begin
    val_neg   = value[DATA_W-1];
    mag       = val_neg ? (~value + 1'b1) : value;
    start_ovf = val_neg ? (mag > DEC_MAX_NEG) : (value > DEC_MAX);
  end
`else
  always_comb begin
    mag       = value;
    start_ovf = value > DEC_MAX;
  end
`endif

  // load_q marks the cycle after ENC in which the output frame is written.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    dec_d      = dec_q;
    ovf_pend_d = ovf_pend_q;
    load_d     = 1'b0;
    bcd_adj    = bcd_q;
`ifdef TUB_SIGNED_EN
    neg_d      = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !load_q) begin
          dec_d      = dec_mode;
          cnt_d      = '0;
          bcd_d      = '0;
          ovf_pend_d = dec_mode & start_ovf;
          shift_d    = dec_mode ? mag : value;
          state_d    = (dec_mode && !start_ovf) ? CONV : ENC;
`ifdef TUB_SIGNED_EN
          neg_d      = dec_mode & val_neg;
`endif
        end
      end
      CONV: begin
        for (int i = 0; i < 8; i++) begin
          if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_d   = {bcd_adj[30:0], shift_q[DATA_W-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntW'(DATA_W - 1)) state_d = ENC;
      end
      ENC: begin
        load_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      dig[i] = dec_q ? bcd_q[(7-i)*4 +: 4] : shift_q[(7-i)*4 +: 4];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dec
    seg_hex_decode u_seg_hex_decode (
      .nibble (dig[g]),
      .seg    (seg[g])
    );
  end

  // Leading zeros are blanked in decimal mode; the rightmost digit is never blanked.
  always_comb begin
    lead  = 1'b1;
    blank = '0;
    frame = seg;
    for (int i = 0; i < 7; i++) begin
      if (dec_q && lead && dig[i] == 4'd0) blank[i] = 1'b1;
      else                                  lead     = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      if (blank[i]) frame[i] = BLANK_CODE;
    end
`ifdef TUB_SIGNED_EN
    for (int i = 0; i < 7; i++) begin
      if (neg_q && blank[i] && !blank[i+1]) frame[i] = SEG_MINUS;
    end
`endif
    if (ovf_pend_q) frame = {8{OVF_CODE}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      dec_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      load_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tub_q      <= {8{BLANK_CODE}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      dec_q      <= dec_d;
      ovf_pend_q <= ovf_pend_d;
      load_q     <= load_d;
      done_q     <= load_q;
      if (load_q) begin
        tub_q <= frame;
        ovf_q <= ovf_pend_q;
      end
    end
  end

`ifdef TUB_SIGNED_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) neg_q <= 1'b0;
    else     neg_q <= neg_d;
  end
`endif

  assign busy  = (state_q != IDLE) | load_q;
  assign done  = done_q;
  assign ovf   = ovf_q;
  assign tub_1 = tub_q[0];
  assign tub_2 = tub_q[1];
  assign tub_3 = tub_q[2];
  assign tub_4 = tub_q[3];
  assign tub_5 = tub_q[4];
  assign tub_6 = tub_q[5];
  assign tub_7 = tub_q[6];
  assign tub_8 = tub_q[7];

endmodule

// File: tb/tb_tub_value_encoder.sv
// Self-checking bench for tub_value_encoder: expected frames queued at start, compared at done.
module tb_tub_value_encoder;

  typedef struct packed {
    logic [63:0] tubs;
    logic        ovf;
  } frame_t;

  typedef struct {
    logic [31:0] v;
    logic        dec;
    int          lat;
    logic [63:0] tubs;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        dec_mode = 1'b0;
  logic        busy, done, ovf;
  logic [7:0]  tub_1, tub_2, tub_3, tub_4, tub_5, tub_6, tub_7, tub_8;

  int checks = 0;
  int failures = 0;
  frame_t exp_q[$];

  logic [7:0] hex_lut [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

  tub_value_encoder u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .value    (value),
    .dec_mode (dec_mode),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .tub_1    (tub_1),
    .tub_2    (tub_2),
    .tub_3    (tub_3),
    .tub_4    (tub_4),
    .tub_5    (tub_5),
    .tub_6    (tub_6),
    .tub_7    (tub_7),
    .tub_8    (tub_8)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] tubs_now();
    return {tub_1, tub_2, tub_3, tub_4, tub_5, tub_6, tub_7, tub_8};
  endfunction

  // Reference model: decimal digits by division, sign and width by digit count.
  function automatic frame_t model(input logic [31:0] v, input logic dec);
    frame_t          f;
    longint unsigned m;
    int              nd;
    bit              neg;
    f.tubs = '0;
    f.ovf  = 1'b0;
    if (!dec) begin
      for (int i = 0; i < 8; i++) f.tubs[63-8*i -: 8] = hex_lut[v[31-4*i -: 4]];
      return f;
    end
    neg = 1'b0;
    m   = v;
`ifdef TUB_SIGNED_EN
    if (v[31]) begin
      neg = 1'b1;
      m   = 64'd4294967296 - m;
    end
`endif
    if ((neg && m > 9_999_999) || (!neg && m > 99_999_999)) begin
      f.ovf  = 1'b1;
      f.tubs = {8{8'h9E}};
      return f;
    end
    nd = 0;
    for (int p = 0; p < 8; p++) begin
      if (p == 0 || m != 0) begin
        f.tubs[p*8 +: 8] = hex_lut[int'(m % 10)];
        nd = p + 1;
      end
      m = m / 10;
    end
    if (neg) f.tubs[nd*8 +: 8] = 8'h02;
    return f;
  endfunction

  task automatic start_req(input logic [31:0] v, input logic dec);
    start    = 1'b1;
    value    = v;
    dec_mode = dec;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done; busy must be high before done, low with it.
  task automatic wait_done(input int budget, output int lat, output bit busy_ok);
    bit seen;
    lat     = -1;
    busy_ok = 1'b1;
    seen    = 1'b0;
    for (int n = 1; n <= budget && !seen; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat  = n;
        seen = 1'b1;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (tubs_now() !== 64'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got tubs=%h busy=%b done=%b ovf=%b want 0/0/0/0",
               tubs_now(), busy, done, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tubs_now() !== 64'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold cycle %0d got tubs=%h busy=%b done=%b ovf=%b", n, tubs_now(),
                 busy, done, ovf);
      end
    end
  endtask

  task automatic test_frames();
    vec_t vecs[6];
    vecs[0] = '{32'h1234ABCD, 1'b0, 2, 64'h60DAF266EE3E9C7A, 1'b0};
    vecs[1] = '{32'd202, 1'b1, 34, 64'h0000000000DAFCDA, 1'b0};
    vecs[2] = '{32'd0, 1'b1, 34, 64'h00000000000000FC, 1'b0};
    vecs[3] = '{32'd99_999_999, 1'b1, 34, {8{8'hF6}}, 1'b0};
    vecs[4] = '{32'd100_000_000, 1'b1, 2, {8{8'h9E}}, 1'b1};
    vecs[5] = '{32'h0, 1'b0, 2, {8{8'hFC}}, 1'b0};
    for (int k = 0; k < 6; k++) begin
      int     lat;
      bit     bok;
      frame_t e;
      exp_q.push_back('{vecs[k].tubs, vecs[k].ovf});
      start_req(vecs[k].v, vecs[k].dec);
      wait_done(60, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (lat != vecs[k].lat) begin
        failures++;
        $display("FAIL frame%0d_latency got=%0d want=%0d", k, lat, vecs[k].lat);
      end
      checks++;
      if (!bok) begin
        failures++;
        $display("FAIL frame%0d_busy_window got=bad want=high until done", k);
      end
      checks++;
      if (tubs_now() !== e.tubs) begin
        failures++;
        $display("FAIL frame%0d_tubs got=%h want=%h", k, tubs_now(), e.tubs);
      end
      checks++;
      if (ovf !== e.ovf) begin
        failures++;
        $display("FAIL frame%0d_ovf got=%b want=%b", k, ovf, e.ovf);
      end
    end
  endtask

  // Starts are issued in the done cycle, so frames run back to back.
  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      int          lat, want_lat;
      bit          bok;
      frame_t      e;
      logic        d;
      logic [31:0] v;
      d = 1'($urandom_range(0, 1));
      v = d ? 32'($urandom_range(0, 110_000_000)) : 32'($urandom);
      e = model(v, d);
      want_lat = (!d || e.ovf) ? 2 : 34;
      exp_q.push_back(e);
      start_req(v, d);
      wait_done(60, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (lat != want_lat) begin
        failures++;
        $display("FAIL rand%0d_latency v=%h dec=%b got=%0d want=%0d", k, v, d, lat, want_lat);
      end
      checks++;
      if (tubs_now() !== e.tubs || ovf !== e.ovf) begin
        failures++;
        $display("FAIL rand%0d_frame v=%h dec=%b got=%h/%b want=%h/%b", k, v, d, tubs_now(),
                 ovf, e.tubs, e.ovf);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat = -1;
    int extra = 0;
    exp_q.push_back('{64'h0000000000DAFCDA, 1'b0});
    start_req(32'd202, 1'b1);
    for (int n = 1; n <= 60 && lat < 0; n++) begin
      if (n == 5) begin
        start    = 1'b1;
        value    = 32'hFFFFFFFF;
        dec_mode = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
    start = 1'b0;
    begin
      frame_t e;
      e = exp_q.pop_front();
      checks++;
      if (lat != 34) begin
        failures++;
        $display("FAIL ignore_latency got=%0d want=34", lat);
      end
      checks++;
      if (tubs_now() !== e.tubs) begin
        failures++;
        $display("FAIL ignore_tubs got=%h want=%h", tubs_now(), e.tubs);
      end
    end
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_no_second_frame got=%0d active cycles want=0", extra);
    end
  endtask

  task automatic test_rst_mid();
    int lat;
    bit bok;
    int dones = 0;
    start_req(32'd100_000_000, 1'b1);
    wait_done(10, lat, bok);
    checks++;
    if (tubs_now() !== {8{8'h9E}} || ovf !== 1'b1) begin
      failures++;
      $display("FAIL pre_rst_ovf_frame got=%h/%b want=%h/1", tubs_now(), ovf, {8{8'h9E}});
    end
    start_req(32'd12345, 1'b1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tubs_now() !== 64'h0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_state got tubs=%h busy=%b done=%b ovf=%b want 0/0/0/0",
               tubs_now(), busy, done, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones != 0 || tubs_now() !== 64'h0) begin
      failures++;
      $display("FAIL rst_mid_no_done got dones=%0d tubs=%h want 0/0", dones, tubs_now());
    end
  endtask

`ifdef TUB_SIGNED_EN
  task automatic test_signed();
    vec_t vecs[4];
    vecs[0] = '{32'hFFFFFF85, 1'b1, 34, 64'h000000000260DAF2, 1'b0};
    vecs[1] = '{32'hFF676980, 1'b1, 2, {8{8'h9E}}, 1'b1};
    vecs[2] = '{32'hFF676981, 1'b1, 34, {8'h02, {7{8'hF6}}}, 1'b0};
    vecs[3] = '{32'h80000000, 1'b1, 2, {8{8'h9E}}, 1'b1};
    for (int k = 0; k < 4; k++) begin
      int     lat;
      bit     bok;
      frame_t e;
      exp_q.push_back('{vecs[k].tubs, vecs[k].ovf});
      start_req(vecs[k].v, vecs[k].dec);
      wait_done(60, lat, bok);
      e = exp_q.pop_front();
      checks++;
      if (lat != vecs[k].lat || tubs_now() !== e.tubs || ovf !== e.ovf) begin
        failures++;
        $display("FAIL signed%0d got lat=%0d tubs=%h ovf=%b want lat=%0d tubs=%h ovf=%b", k,
                 lat, tubs_now(), ovf, vecs[k].lat, e.tubs, e.ovf);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frames();
    test_random();
    test_ignore_start();
    test_rst_mid();
`ifdef TUB_SIGNED_EN
    test_signed();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
